// File: rtl/fc_act_unit.sv
// fc_act_unit -- activation stage between the FC core result stream and the
// loader's store-output path.
//
// Each result accepted from the FC core is registered in stage S1. The
// per-layer activation is applied combinationally out of S1, and the result is
// pushed into a small elastic FIFO. Exactly cout results are accepted and
// handed downstream per layer. A one-cycle done pulse follows the last pop.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             one-cycle layer start, honoured only in IDLE
//   act_type, cout    activation code / result count, latched on start
//   din_valid/ready   FC core result handshake, din_data signed DATA_W
//   dout_valid/ready  downstream handshake, dout_data signed DATA_W
//   busy              high while the layer is running
//   done              one-cycle pulse when the layer has completed
module fc_act_unit #(
    parameter int DATA_W     = 16,
    parameter int FRAC_BITS  = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        act_type,
    input  logic [CNT_W-1:0]  cout,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Activation constants in the DATA_W+1 intermediate format
    localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0] ONE_X   = (DATA_W+1)'(1) << FRAC_BITS;
    localparam logic signed [DATA_W:0] HALF_X  = (DATA_W+1)'(1) << (FRAC_BITS-1);
    localparam logic signed [DATA_W:0] SIX_X   = (DATA_W+1)'(6) << FRAC_BITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic               busy_q, done_q;
    logic [4:0]         act_q;
    logic [CNT_W-1:0]   cout_q;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic               s1_valid_q;
    logic [DATA_W-1:0]  s1_data_q;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q, count_d;

    logic               fifo_full, fifo_empty;
    logic               pop, s1_move, accept, last_pop, start_ok;
    logic [DATA_W-1:0]  act_y;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign dout_valid = ~fifo_empty;
    assign dout_data  = mem_q[rd_ptr_q];
    assign pop        = dout_valid && dout_ready;
    // S1 may drain into a full FIFO when the head leaves in the same cycle,
    // which makes din_ready depend on dout_ready while full.
    assign s1_move    = s1_valid_q && (~fifo_full || pop);
    assign din_ready  = (state_q == S_RUN) && (acc_cnt_q < cout_q) &&
                        (~s1_valid_q || s1_move);
    assign accept     = din_valid && din_ready;
    assign last_pop   = pop && (out_cnt_q == cout_q - CNT_W'(1));
    assign start_ok   = (state_q == S_IDLE) && start;
    assign busy       = busy_q;
    assign done       = done_q;

    // ------------------------------------------------------------------
    // Layer control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= '0;
            cout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        act_q  <= act_type;
                        cout_q <= cout;
                        if (cout == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last_pop) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accept / output counters
    // ------------------------------------------------------------------
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        out_cnt_d = out_cnt_q;
        if (start_ok) begin
            acc_cnt_d = '0;
            out_cnt_d = '0;
        end else begin
            if (accept) acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (pop)    out_cnt_d = out_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Input stage S1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= din_data;
        end else if (s1_move) begin
            s1_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Activation, computed one bit wider than the data path and then
    // saturated back to DATA_W.
    // ------------------------------------------------------------------
    always_comb begin
        logic signed [DATA_W:0] xe;
        logic signed [DATA_W:0] ye;
        xe = {s1_data_q[DATA_W-1], s1_data_q};
        ye = xe;
        case (act_q)
            5'd1: ye = xe[DATA_W] ? '0 : xe;
            5'd2: ye = xe[DATA_W] ? (xe >>> 3) : xe;
            5'd3: begin
                ye = (xe >>> 2) + HALF_X;
                if (ye[DATA_W])     ye = '0;
                else if (ye > ONE_X) ye = ONE_X;
            end
            5'd4: begin
                if (xe[DATA_W])      ye = '0;
                else if (xe > SIX_X) ye = SIX_X;
                else                 ye = xe;
            end
            default: ye = xe;
        endcase
        if (ye > SAT_MAX)      ye = SAT_MAX;
        else if (ye < SAT_MIN) ye = SAT_MIN;
        act_y = ye[DATA_W-1:0];
    end

    // ------------------------------------------------------------------
    // Output FIFO. The storage is reset too so dout_data reads 0 after reset.
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({s1_move, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (s1_move) begin
                mem_q[wr_ptr_q] <= act_y;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: doc/fc_act_unit.md
Name: fc_act_unit

Overview:
- Activation stage between the FC core output stream and the data loader's store-output path.
- Applies the decoded per-layer activation (act_type) to each 16-bit FC result.
- Buffers results in a small elastic FIFO and counts exactly cout results per layer.
- Raises a one-cycle done pulse when the last activated result has been handed downstream.

Parameters:
- DATA_W, 16, width of the signed fixed-point data path.
- FRAC_BITS, 8, number of fractional bits (Q8.8 at the defaults).
- FIFO_DEPTH, 2, number of output FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 12, width of cout and of the internal counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a layer; sampled only in IDLE.
- act_type  in  5  activation code, latched on start.
- cout  in  CNT_W  number of results for this layer, latched on start.
- din_valid  in  1  FC core result valid.
- din_ready  out  1  this block accepts din_data this cycle.
- din_data  in  DATA_W  FC core result, signed.
- dout_valid  out  1  activated result available.
- dout_ready  in  1  downstream (loader) takes dout_data this cycle.
- dout_data  out  DATA_W  activated result, signed.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the layer completes.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - state=IDLE; all counters 0; S1 and FIFO empty.
  - din_ready=0, dout_valid=0, dout_data=0, busy=0, done=0.
  - Reset mid-layer discards all buffered data; no done pulse is produced.
- State machine IDLE, RUN, DONE:
  - IDLE: on start, latch act_type_r and cout_r, clear acc_cnt and out_cnt, go to RUN. If cout=0, go to DONE instead.
  - RUN: when a pop occurs with out_cnt==cout_r-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Input stage S1: one register plus a valid bit.
  - din_ready = (state==RUN) && (acc_cnt<cout_r) && (~s1_valid || s1_move).
  - Accept occurs when din_valid && din_ready; it loads S1 and increments acc_cnt.
  - s1_move = s1_valid && (~fifo_full || pop).
  - s1_move and accept may occur in the same cycle.
  - din_ready depends combinationally on dout_ready when the FIFO is full; this path is intended.
- Activation is combinational from S1; the result is written into the FIFO on s1_move.
  - Computation uses DATA_W+1-bit signed intermediates; every result is saturated to the signed DATA_W range.
  - 0 NONE: y=x.
  - 1 RELU: y = (x<0) ? 0 : x.
  - 2 LEAKY: y = (x<0) ? (x>>>3) : x. Arithmetic shift, rounds toward -inf.
  - 3 HSIGMOID: y = clamp((x>>>2) + (1<<(FRAC_BITS-1)), 0, 1<<FRAC_BITS).
  - 4 RELU6: y = clamp(x, 0, 6<<FRAC_BITS).
  - Any other code: treated as NONE.
- Output FIFO:
  - dout_valid = ~fifo_empty; dout_data = head entry, held stable while dout_valid && ~dout_ready.
  - pop = dout_valid && dout_ready; each pop increments out_cnt.
  - Simultaneous push and pop when full is allowed and keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: an input accepted at edge k gives dout_valid=1 after edge k+1, provided the FIFO is not full.
- Throughput: 1 result/cycle sustained when dout_ready is held high.
- Extra inputs beyond cout are never accepted: din_ready stays 0 once acc_cnt==cout_r.
- busy = (state==RUN).

Test Plan:
- Basic RELU: start with act_type=1, cout=4; inputs 0x0100, 0xFF00, 0x7FFF, 0x8000; dout_ready=1.
  - Required outputs: 0x0100, 0x0000, 0x7FFF, 0x0000.
  - First dout_valid 2 cycles after the first accept; done pulses once, one cycle after the 4th pop.
- Activation arithmetic, cout=1 per case:
  - LEAKY on 0xFFF8 (-8) gives 0xFFFF; LEAKY on 0xFFF9 (-7) gives 0xFFFF.
  - HSIGMOID on 0x0400 gives 0x0100; on 0xFC00 gives 0x0000; on 0x0000 gives 0x0080.
  - RELU6 on 0x0700 gives 0x0600.
- Backpressure, act_type=0, cout=6, din_valid always 1, dout_ready=0 for 10 cycles:
  - Exactly FIFO_DEPTH+1=3 inputs are accepted and dout_data is held at the first value.
  - After releasing dout_ready, the 6 outputs arrive in order with no loss or duplication.
- Count limit and edge cases:
  - cout=3 with 5 valid inputs: din_ready falls after the 3rd accept and done pulses after the 3rd pop.
  - cout=0: done pulses 1 cycle after start and no input is accepted.
  - start pulsed during RUN: no effect.
- Reset mid-layer: assert rst after 2 of 5 inputs.
  - All outputs go to reset values immediately, without waiting for a clock edge, and no done pulse occurs.
  - A new start with cout=2 then completes normally.
- Random stream: 200 inputs with random din_valid/dout_ready and random act_type per layer.
  - Outputs must match a reference model bit-exact, with exactly one done per layer.
